// File: rtl/mmio_timer.sv
// Memory-mapped interval timer responder: CTRL/PERIOD/COUNT/STATUS in a 4-word window, tri-state reads.
// Optional interrupt output and CTRL.IRQEN bit are built when TIMER_IRQ_EN is defined.
module mmio_timer #(
   parameter logic [8:0]  BASE     = 9'h180,
   parameter logic [15:0] PRESCALE = 16'd4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  mem_cmd,
   input  logic [8:0]  mem_addr,
   input  logic [15:0] write_data,
   output logic [15:0] read_data
`ifdef TIMER_IRQ_EN
   ,
   output logic        irq
`endif
);

   localparam logic [1:0] MREAD      = 2'b01;
   localparam logic [1:0] MWRITE     = 2'b10;
   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_PERIOD = 2'd1;
   localparam logic [1:0] REG_COUNT  = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   logic        w_sel;
   logic        w_rd;
   logic        w_wr;
   logic        w_wr_ctrl;
   logic        w_wr_period;
   logic        w_wr_count;
   logic        w_wr_status;
   logic        w_tick;
   logic        w_expire;
   logic        w_irqen;
   logic [15:0] w_rdata;

   logic        r_en;
   logic        r_auto;
   logic [15:0] r_period;
   logic [15:0] r_count;
   logic [15:0] r_presc;
   logic        r_exp;
   logic [7:0]  r_wraps;

   assign w_sel       = (mem_addr[8:2] == BASE[8:2]);
   assign w_rd        = w_sel && (mem_cmd == MREAD);
   assign w_wr        = w_sel && (mem_cmd == MWRITE);
   assign w_wr_ctrl   = w_wr && (mem_addr[1:0] == REG_CTRL);
   assign w_wr_period = w_wr && (mem_addr[1:0] == REG_PERIOD);
   assign w_wr_count  = w_wr && (mem_addr[1:0] == REG_COUNT);
   assign w_wr_status = w_wr && (mem_addr[1:0] == REG_STATUS);

   assign w_tick   = r_en && (r_presc == PRESCALE - 16'd1);
   assign w_expire = w_tick && (r_count <= 16'd1);

   // A CTRL write restarts the prescaler so the first tick lands PRESCALE cycles later.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_presc <= '0;
      end else if (w_wr_ctrl || !r_en || w_tick) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_en   <= 1'b0;
         r_auto <= 1'b0;
      end else if (w_wr_ctrl) begin
         r_en   <= write_data[0];
         r_auto <= write_data[1];
      end else if (w_expire && !r_auto) begin
         r_en   <= 1'b0;
      end
   end

`ifdef TIMER_IRQ_EN
   logic r_irqen;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_irqen <= 1'b0;
      end else if (w_wr_ctrl) begin
         r_irqen <= write_data[3];
      end
   end

   assign w_irqen = r_irqen;
   assign irq     = r_exp & r_irqen;
`else
   assign w_irqen = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_period <= '0;
      end else if (w_wr_period) begin
         r_period <= write_data;
      end
   end

   // Reload uses the PERIOD value held before any same-cycle PERIOD write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (w_wr_count) begin
         r_count <= write_data;
      end else if (w_expire) begin
         r_count <= r_auto ? r_period : 16'd0;
      end else if (w_tick) begin
         r_count <= r_count - 16'd1;
      end
   end

   // Expiry beats an EXP clear; a WRAPS clear beats the increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_exp   <= 1'b0;
         r_wraps <= '0;
      end else begin
         if (w_expire) begin
            r_exp <= 1'b1;
         end else if (w_wr_status && write_data[0]) begin
            r_exp <= 1'b0;
         end
         if (w_wr_status && write_data[8]) begin
            r_wraps <= '0;
         end else if (w_expire) begin
            r_wraps <= r_wraps + 8'd1;
         end
      end
   end

   always_comb begin
      w_rdata = '0;
      case (mem_addr[1:0])
         REG_CTRL:   w_rdata = {12'd0, w_irqen, 1'b0, r_auto, r_en};
         REG_PERIOD: w_rdata = r_period;
         REG_COUNT:  w_rdata = r_count;
         REG_STATUS: w_rdata = {r_wraps, 7'd0, r_exp};
         default:    w_rdata = '0;
      endcase
   end

   assign read_data = w_rd ? w_rdata : 16'bz;

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: two responders (PRESCALE 4 and 1) share one pulled-up read bus.
// IRQ checks are built when TIMER_IRQ_EN is defined, CTRL[3] read-as-zero checks otherwise.
module tb_mmio_timer;

   localparam logic [1:0]  MNOT     = 2'b00;
   localparam logic [1:0]  MREAD    = 2'b01;
   localparam logic [1:0]  MWRITE   = 2'b10;
   localparam logic [8:0]  A_CTRL   = 9'h180;
   localparam logic [8:0]  A_PERIOD = 9'h181;
   localparam logic [8:0]  A_COUNT  = 9'h182;
   localparam logic [8:0]  A_STATUS = 9'h183;
   localparam logic [8:0]  F_CTRL   = 9'h1C0;
   localparam logic [8:0]  F_COUNT  = 9'h1C2;
   localparam logic [8:0]  F_STATUS = 9'h1C3;
   // Pull-ups make an undriven (high-Z) bus read as all ones.
   localparam logic [15:0] RELEASED = 16'hFFFF;

   logic        clk        = 1'b0;
   logic        reset      = 1'b1;
   logic [1:0]  mem_cmd    = MNOT;
   logic [8:0]  mem_addr   = '0;
   logic [15:0] write_data = '0;
   wire  [15:0] read_data;

   int unsigned cyc     = 0;
   int unsigned last_wr = 0;
   int unsigned e       = 0;
   int          n_checks = 0;
   int          n_err    = 0;
   logic [15:0] v;

`ifdef TIMER_IRQ_EN
   logic irq;
   logic irq_fast;
`endif

   for (genvar g = 0; g < 16; g++) begin : g_pull
      pullup pu (read_data[g]);
   end

   mmio_timer #(.BASE(9'h180), .PRESCALE(16'd4)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .mem_cmd    (mem_cmd),
      .mem_addr   (mem_addr),
      .write_data (write_data),
      .read_data  (read_data)
`ifdef TIMER_IRQ_EN
      ,
      .irq        (irq)
`endif
   );

   mmio_timer #(.BASE(9'h1C0), .PRESCALE(16'd1)) u_fast (
      .clk        (clk),
      .reset      (reset),
      .mem_cmd    (mem_cmd),
      .mem_addr   (mem_addr),
      .write_data (write_data),
      .read_data  (read_data)
`ifdef TIMER_IRQ_EN
      ,
      .irq        (irq_fast)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic rd_now(input logic [8:0] a, output logic [15:0] d);
      mem_cmd  = MREAD;
      mem_addr = a;
      #1;
      d        = read_data;
      mem_cmd  = MNOT;
   endtask

   task automatic rd(input logic [8:0] a, output logic [15:0] d);
      @(negedge clk);
      rd_now(a, d);
   endtask

   task automatic wr(input logic [8:0] a, input logic [15:0] d);
      @(negedge clk);
      mem_cmd    = MWRITE;
      mem_addr   = a;
      write_data = d;
      @(posedge clk);
      #1;
      last_wr = cyc;
      mem_cmd = MNOT;
   endtask

   // Advance to just after rising edge number n.
   task automatic goto(input int unsigned n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Reset mid-count
      wr(A_PERIOD, 16'h0007);
      wr(A_COUNT, 16'h0005);
      wr(A_CTRL, 16'h0003);
      rd(A_COUNT, v);         chk("pre_reset_count", v, 16'h0005);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #2;
      reset = 1'b0;
      rd(A_CTRL, v);          chk("rst_ctrl", v, 16'h0000);
      rd_now(A_PERIOD, v);    chk("rst_period", v, 16'h0000);
      rd_now(A_COUNT, v);     chk("rst_count", v, 16'h0000);
      rd_now(A_STATUS, v);    chk("rst_status", v, 16'h0000);
      @(negedge clk);
      mem_cmd  = MNOT;
      mem_addr = A_CTRL;
      #1;
      chk("idle_release", read_data, RELEASED);
      repeat (6) @(posedge clk);
      rd(A_COUNT, v);         chk("abandoned_count", v, 16'h0000);

      // One-shot: expiry exactly 12 cycles after the CTRL write edge
      wr(A_PERIOD, 16'h0003);
      wr(A_COUNT, 16'h0003);
      wr(A_CTRL, 16'h0001);
      e = last_wr;
      goto(e + 11);
      rd(A_STATUS, v);        chk("os_status_e11", v, 16'h0000);
      rd_now(A_COUNT, v);     chk("os_count_e11", v, 16'h0001);
      goto(e + 12);
      rd(A_STATUS, v);        chk("os_status_e12", v, 16'h0101);
      rd_now(A_COUNT, v);     chk("os_count_e12", v, 16'h0000);
      rd_now(A_CTRL, v);      chk("os_ctrl_e12", v, 16'h0000);
      goto(e + 20);
      rd(A_COUNT, v);         chk("os_stopped", v, 16'h0000);
      wr(A_STATUS, 16'h0101);
      rd(A_STATUS, v);        chk("os_clear", v, 16'h0000);

      // Auto-reload: count alternates 2,1 every 4 cycles; expiry every 8
      wr(A_COUNT, 16'h0002);
      wr(A_PERIOD, 16'h0002);
      wr(A_CTRL, 16'h0003);
      e = last_wr;
      for (int k = 1; k <= 40; k++) begin
         goto(e + k);
         rd(A_COUNT, v);
         chk("auto_count", v, (((k / 4) % 2) == 0) ? 16'h0002 : 16'h0001);
      end
      rd_now(A_STATUS, v);    chk("auto_status", v, 16'h0501);
      goto(e + 41);
      wr(A_STATUS, 16'h0101);
      rd(A_STATUS, v);        chk("auto_clear", v, 16'h0000);
      goto(e + 47);
      wr(A_STATUS, 16'h0101);
      rd(A_STATUS, v);        chk("exp_vs_clear", v, 16'h0001);
      rd_now(A_COUNT, v);     chk("reload_count", v, 16'h0002);
      goto(e + 51);
      wr(A_COUNT, 16'h0010);
      rd(A_COUNT, v);         chk("tick_vs_count_wr", v, 16'h0010);
      goto(e + 56);
      rd(A_COUNT, v);         chk("tick_after_wr", v, 16'h000F);
      goto(e + 57);
      wr(A_CTRL, 16'h0003);
      goto(e + 61);
      rd(A_COUNT, v);         chk("ctrl_clears_presc", v, 16'h000F);
      goto(e + 62);
      rd(A_COUNT, v);         chk("tick_after_ctrl", v, 16'h000E);

      // PERIOD write on the reload edge: COUNT takes the old PERIOD
      wr(A_CTRL, 16'h0000);
      wr(A_COUNT, 16'h0001);
      wr(A_PERIOD, 16'h0005);
      wr(A_CTRL, 16'h0003);
      e = last_wr;
      goto(e + 3);
      wr(A_PERIOD, 16'h0009);
      rd(A_COUNT, v);         chk("reload_old_period", v, 16'h0005);
      rd_now(A_PERIOD, v);    chk("period_new", v, 16'h0009);
      wr(A_CTRL, 16'h0000);

      // Bus isolation
      rd(9'h140, v);          chk("iso_rd_140", v, RELEASED);
      rd(9'h17F, v);          chk("iso_rd_17f", v, RELEASED);
      wr(9'h184, 16'hFFFF);
      rd(9'h181, v);          chk("iso_wr184_period", v, 16'h0009);
      rd_now(A_CTRL, v);      chk("iso_wr184_ctrl", v, 16'h0000);

      // PRESCALE = 1 instance on the same bus: tick every cycle
      wr(F_COUNT, 16'h0003);
      wr(F_CTRL, 16'h0001);
      e = last_wr;
      goto(e + 2);
      rd(F_STATUS, v);        chk("fast_status_e2", v, 16'h0000);
      rd_now(F_COUNT, v);     chk("fast_count_e2", v, 16'h0001);
      goto(e + 3);
      rd(F_STATUS, v);        chk("fast_status_e3", v, 16'h0101);
      rd_now(F_COUNT, v);     chk("fast_count_e3", v, 16'h0000);

`ifdef TIMER_IRQ_EN
      wr(A_STATUS, 16'h0101);
      wr(A_COUNT, 16'h0001);
      wr(A_CTRL, 16'h0009);
      e = last_wr;
      rd(A_CTRL, v);          chk("irqen_rw", v, 16'h0009);
      goto(e + 3);
      rd(A_STATUS, v);        chk("irq_pre_status", v, 16'h0000);
      chk("irq_low", {15'd0, irq}, 16'h0000);
      goto(e + 4);
      rd(A_STATUS, v);        chk("irq_exp_status", v, 16'h0101);
      chk("irq_high", {15'd0, irq}, 16'h0001);
      chk("irq_fast_off", {15'd0, irq_fast}, 16'h0000);
      rd_now(A_CTRL, v);      chk("irq_ctrl_after", v, 16'h0008);
      wr(A_STATUS, 16'h0001);
      chk("irq_clear", {15'd0, irq}, 16'h0000);
      rd(A_STATUS, v);        chk("irq_clear_status", v, 16'h0100);
`else
      wr(A_CTRL, 16'h0009);
      rd(A_CTRL, v);          chk("irqen_absent", v, 16'h0001);
      wr(A_CTRL, 16'h0000);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/mmio_timer.md
Name: mmio_timer

Overview:
- Memory-mapped interval timer that acts as a responder on the CPU memory bus (`mem_cmd`, `mem_addr`, `write_data`, `read_data`).
- Sits beside the RAM, LED and switch responders at the top level.
- Decodes its own 4-word address window and drives `read_data` only when it is addressed; otherwise it drives high-Z, so it shares the bus with the other read sources.
- Counts down a programmed period, flags expiry, and optionally reloads.

Parameters:
- BASE, 9'h180: word address of register 0. Must be 4-aligned and must not overlap RAM (bit 8 = 0), LEDs (9'h100) or switches (9'h140).
- PRESCALE, 16'd4: clock cycles per count decrement. Legal range 1..65535.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_cmd  input  2  bus command: `MNOT` = 2'b00, `MREAD` = 2'b01, `MWRITE` = 2'b10.
- mem_addr  input  9  bus word address.
- write_data  input  16  bus write data.
- read_data  output  16  tri-state bus read data.
- irq  output  1  interrupt request; present only with TIMER_IRQ_EN.

Behaviour:
- Decode:
  - sel = (mem_addr[8:2] == BASE[8:2]).
  - Register index = mem_addr[1:0].
  - A command other than `MREAD`/`MWRITE` is ignored.
- Registers:
  - 0 CTRL: [0] EN, [1] AUTO, [3] IRQEN (optional feature only). Other bits read 0.
  - 1 PERIOD: 16-bit reload value.
  - 2 COUNT: read returns the live count; write loads the count.
  - 3 STATUS: [0] EXP sticky flag, [15:8] WRAPS expiry counter (wraps 255→0). Other bits read 0.
- Read:
  - Combinational: read_data = selected register when mem_cmd == `MREAD` && sel; otherwise 16'bz.
  - No clock latency.
- Write:
  - Takes effect on the rising clk edge when mem_cmd == `MWRITE` && sel.
  - STATUS write: write_data[0] = 1 clears EXP; write_data[8] = 1 clears WRAPS. It never sets bits.
  - A CTRL write also clears the prescaler.
- Reset (async): CTRL, PERIOD, COUNT, STATUS and the prescaler all go to 0; irq = 0. A reset mid-count abandons the count immediately.
- Prescaler:
  - While EN = 0 it is held at 0.
  - While EN = 1 it increments; when it equals PRESCALE-1 it returns to 0 and generates a one-cycle tick.
  - With PRESCALE = 1 a tick occurs every cycle.
  - The first tick arrives PRESCALE cycles after the edge that sets EN.
- On a tick (EN = 1):
  - COUNT > 1: COUNT <= COUNT-1.
  - COUNT <= 1 (expire): EXP <= 1 and WRAPS <= WRAPS+1.
    - AUTO = 1: COUNT <= PERIOD and EN stays 1.
    - AUTO = 0: COUNT <= 0 and EN <= 0 (one-shot stop).
  - PERIOD = 0 with AUTO = 1 gives an expiry on every tick.
- Simultaneous events:
  - A bus write to COUNT or CTRL in the same cycle as a tick: the bus write wins for that register. The tick's EXP/WRAPS update still occurs.
  - Expire and a STATUS clear in the same cycle: the set wins (EXP = 1). WRAPS clear wins over increment.
  - A PERIOD write in the same cycle as an auto-reload: COUNT reloads the old PERIOD.

Optional Feature:
- Macro: TIMER_IRQ_EN.
- Defined:
  - CTRL[3] IRQEN is implemented and read/write.
  - Port irq = EXP & IRQEN, registered-state based with no extra latency, so it falls on the edge that clears EXP.
- Undefined:
  - irq port is absent.
  - CTRL[3] ignores writes and reads 0.

Test Plan:
- Reset: assert reset mid-count with COUNT = 16'h0005, then read all four registers → all read 16'h0000. read_data = 16'bz with mem_cmd = 2'b00.
- One-shot: PRESCALE = 4; write PERIOD/COUNT = 3, then CTRL = 16'h0001 → EXP sets exactly 12 cycles after the CTRL write edge. COUNT reads 0, CTRL reads 16'h0000, STATUS reads 16'h0101.
- Auto-reload: COUNT = 2, PERIOD = 2, CTRL = 16'h0003, run 40 cycles at PRESCALE = 4 → WRAPS = 5 and COUNT reads 2 or 1 (never 0). Writing STATUS = 16'h0101 → reads 16'h0000 (unless an expiry lands in the same cycle).
- Bus isolation: `MREAD` at 9'h140 and 9'h17F → read_data = 16'bz. `MWRITE` at 9'h184 → no register changes. `MREAD` at 9'h181 → PERIOD.
- Collision: a tick and an `MWRITE` COUNT = 16'h0010 in the same cycle → COUNT reads 16'h0010. Expiry and a STATUS clear in the same cycle → EXP = 1.
- IRQ (TIMER_IRQ_EN): CTRL = 16'h0009, COUNT = 1 → irq rises with EXP. Writing STATUS = 16'h0001 → irq = 0 on the next edge. Build without the macro → CTRL write 16'h0009 reads back 16'h0001.
